// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the IFU/LSU memory arbiter.
// Owner encoding doubles as the bit index into the one-hot grant vector.
package mem_arbiter_pkg;

  localparam int unsigned AddrWDefault = 32;
  localparam int unsigned DataWDefault = 32;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbReq  = 2'd1,
    ArbWait = 2'd2
  } arb_state_e;

  typedef enum logic {
    OwnIfu = 1'b0,
    OwnLsu = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational grant selection between IFU and LSU requesters.
// MEM_ARB_RR_EN: round-robin on conflict; otherwise LSU wins on conflict.
module mem_arbiter_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic       ifu_valid_i,
  input  logic       lsu_valid_i,
`ifdef MEM_ARB_RR_EN
  input  owner_e     last_grant_i,
`endif
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (ifu_valid_i && lsu_valid_i) begin
`ifdef MEM_ARB_RR_EN
      // Whoever was not served last gets the port.
      if (last_grant_i == OwnIfu) begin
        gnt_o[OwnLsu] = 1'b1;
      end else begin
        gnt_o[OwnIfu] = 1'b1;
      end
`else
      gnt_o[OwnLsu] = 1'b1;
`endif
    end else if (lsu_valid_i) begin
      gnt_o[OwnLsu] = 1'b1;
    end else if (ifu_valid_i) begin
      gnt_o[OwnIfu] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding memory port arbiter between fetch (IFU) and load/store (LSU).
// Optional round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                ifu_req_valid_i,
  output logic                ifu_req_ready_o,
  input  logic [ADDR_W-1:0]   ifu_addr_i,
  output logic                ifu_rsp_valid_o,
  output logic [DATA_W-1:0]   ifu_rdata_o,

  input  logic                lsu_req_valid_i,
  output logic                lsu_req_ready_o,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic                lsu_wen_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_wmask_i,
  output logic                lsu_rsp_valid_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,

  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_wen_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic                mem_rsp_valid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,

  output logic                err_o
);

  localparam int unsigned MaskW = DATA_W / 8;

  arb_state_e        state_q;
  owner_e            owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MaskW-1:0]  wmask_q;
  logic              mem_req_valid_q;
  logic              err_q;

  logic [1:0] gnt;
  logic       in_idle;
  logic       ifu_hs;
  logic       lsu_hs;
  logic       rsp_fire;

`ifdef MEM_ARB_RR_EN
  owner_e last_grant_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_q <= OwnIfu;
    end else if (lsu_hs) begin
      last_grant_q <= OwnLsu;
    end else if (ifu_hs) begin
      last_grant_q <= OwnIfu;
    end
  end
`endif

  mem_arbiter_arb_pick u_arb_pick (
    .ifu_valid_i  (ifu_req_valid_i),
    .lsu_valid_i  (lsu_req_valid_i),
`ifdef MEM_ARB_RR_EN
    .last_grant_i (last_grant_q),
`endif
    .gnt_o        (gnt)
  );

  // Ready is a combinational grant in IDLE; held low while reset is applied.
  assign in_idle         = (state_q == ArbIdle) && !rst_i;
  assign ifu_req_ready_o = in_idle && gnt[OwnIfu];
  assign lsu_req_ready_o = in_idle && gnt[OwnLsu];
  assign ifu_hs          = ifu_req_valid_i && ifu_req_ready_o;
  assign lsu_hs          = lsu_req_valid_i && lsu_req_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ArbIdle;
      owner_q         <= OwnIfu;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      wdata_q         <= '0;
      wmask_q         <= '0;
      mem_req_valid_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      if (mem_rsp_valid_i && (state_q != ArbWait)) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        ArbIdle: begin
          if (lsu_hs) begin
            owner_q         <= OwnLsu;
            addr_q          <= lsu_addr_i;
            wen_q           <= lsu_wen_i;
            wdata_q         <= lsu_wdata_i;
            wmask_q         <= lsu_wmask_i;
            mem_req_valid_q <= 1'b1;
            state_q         <= ArbReq;
          end else if (ifu_hs) begin
            owner_q         <= OwnIfu;
            addr_q          <= ifu_addr_i;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            mem_req_valid_q <= 1'b1;
            state_q         <= ArbReq;
          end
        end
        ArbReq: begin
          if (mem_req_ready_i) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= ArbWait;
          end
        end
        ArbWait: begin
          if (mem_rsp_valid_i) begin
            state_q <= ArbIdle;
          end
        end
        default: begin
          mem_req_valid_q <= 1'b0;
          state_q         <= ArbIdle;
        end
      endcase
    end
  end

  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_addr_o      = addr_q;
  assign mem_wen_o       = wen_q;
  assign mem_wdata_o     = wdata_q;
  assign mem_wmask_o     = wmask_q;
  assign err_o           = err_q;

  // Response goes straight through to its owner in the same cycle.
  assign rsp_fire        = (state_q == ArbWait) && mem_rsp_valid_i;
  assign ifu_rsp_valid_o = rsp_fire && (owner_q == OwnIfu);
  assign lsu_rsp_valid_o = rsp_fire && (owner_q == OwnLsu);
  assign ifu_rdata_o     = ifu_rsp_valid_o ? mem_rdata_i : '0;
  assign lsu_rdata_o     = lsu_rsp_valid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grants, memory fields and responses.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit Rr = 1'b1;
`else
  localparam bit Rr = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        ifu_req_valid_i, ifu_req_ready_o, ifu_rsp_valid_o;
  logic [31:0] ifu_addr_i, ifu_rdata_o;
  logic        lsu_req_valid_i, lsu_req_ready_o, lsu_wen_i, lsu_rsp_valid_o;
  logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
  logic [3:0]  lsu_wmask_i;
  logic        mem_req_valid_o, mem_req_ready_i, mem_wen_o, mem_rsp_valid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_wmask_o;
  logic        err_o;

  int checks = 0;
  int failures = 0;

  // Requester model: pending flags plus the fields each requester is holding.
  bit          ifu_pend, lsu_pend;
  logic [31:0] ifu_a, lsu_a, lsu_d;
  logic        lsu_w;
  logic [3:0]  lsu_m;
  bit          m_last_lsu;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .ifu_req_valid_i (ifu_req_valid_i),
    .ifu_req_ready_o (ifu_req_ready_o),
    .ifu_addr_i      (ifu_addr_i),
    .ifu_rsp_valid_o (ifu_rsp_valid_o),
    .ifu_rdata_o     (ifu_rdata_o),
    .lsu_req_valid_i (lsu_req_valid_i),
    .lsu_req_ready_o (lsu_req_ready_o),
    .lsu_addr_i      (lsu_addr_i),
    .lsu_wen_i       (lsu_wen_i),
    .lsu_wdata_i     (lsu_wdata_i),
    .lsu_wmask_i     (lsu_wmask_i),
    .lsu_rsp_valid_o (lsu_rsp_valid_o),
    .lsu_rdata_o     (lsu_rdata_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_addr_o      (mem_addr_o),
    .mem_wen_o       (mem_wen_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_wmask_o     (mem_wmask_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rdata_i     (mem_rdata_i),
    .err_o           (err_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    ifu_req_valid_i = ifu_pend;
    ifu_addr_i      = ifu_a;
    lsu_req_valid_i = lsu_pend;
    lsu_addr_i      = lsu_a;
    lsu_wen_i       = lsu_w;
    lsu_wdata_i     = lsu_d;
    lsu_wmask_i     = lsu_m;
  endtask

  task automatic new_ifu();
    ifu_pend = 1'b1;
    ifu_a    = $urandom;
  endtask

  task automatic new_lsu();
    lsu_pend = 1'b1;
    lsu_a    = $urandom;
    lsu_w    = 1'($urandom_range(0, 1));
    lsu_d    = $urandom;
    lsu_m    = 4'($urandom);
  endtask

  task automatic do_reset();
    rst_i           = 1'b1;
    ifu_pend        = 1'b0;
    lsu_pend        = 1'b0;
    ifu_a           = '0;
    lsu_a           = '0;
    lsu_w           = 1'b0;
    lsu_d           = '0;
    lsu_m           = '0;
    drive_reqs();
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rdata_i     = '0;
    m_last_lsu      = 1'b0;
    step();
    step();
    rst_i = 1'b0;
    step();
  endtask

  // One full transaction from the current pending set; returns whether LSU was granted.
  task automatic run_one(input int rdly, input int sdly, input logic [31:0] rdata,
                         output bit got_lsu);
    bit          exp_lsu;
    logic [31:0] ea, ed;
    logic        ew;
    logic [3:0]  em;
    if (ifu_pend && lsu_pend) exp_lsu = Rr ? !m_last_lsu : 1'b1;
    else                      exp_lsu = lsu_pend;
    ea = exp_lsu ? lsu_a : ifu_a;
    ew = exp_lsu ? lsu_w : 1'b0;
    ed = exp_lsu ? lsu_d : 32'h0;
    em = exp_lsu ? lsu_m : 4'h0;
    drive_reqs();
    #1;
    checks++;
    if ({ifu_req_ready_o, lsu_req_ready_o} !== {!exp_lsu, exp_lsu}) begin
      failures++;
      $display("FAIL grant: ifu_ready/lsu_ready=%b%b required %b%b", ifu_req_ready_o,
               lsu_req_ready_o, !exp_lsu, exp_lsu);
    end
    got_lsu = lsu_req_ready_o;
    step();
    if (exp_lsu) lsu_pend = 1'b0;
    else         ifu_pend = 1'b0;
    m_last_lsu = exp_lsu;
    drive_reqs();
    for (int k = 0; k <= rdly; k++) begin
      mem_req_ready_i = (k == rdly);
      #1;
      checks++;
      if ({mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_wmask_o}
          !== {1'b1, ea, ew, ed, em}) begin
        failures++;
        $display("FAIL mem_req: v=%b a=%h w=%b d=%h m=%h required v=1 a=%h w=%b d=%h m=%h",
                 mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_wmask_o,
                 ea, ew, ed, em);
      end
      checks++;
      if ({ifu_req_ready_o, lsu_req_ready_o} !== 2'b00) begin
        failures++;
        $display("FAIL busy_ready_req: ready=%b%b required 00", ifu_req_ready_o,
                 lsu_req_ready_o);
      end
      step();
    end
    mem_req_ready_i = 1'b0;
    for (int k = 0; k < sdly; k++) begin
      #1;
      checks++;
      if ({mem_req_valid_o, ifu_rsp_valid_o, lsu_rsp_valid_o, ifu_req_ready_o,
           lsu_req_ready_o} !== 5'b0) begin
        failures++;
        $display("FAIL wait_quiet: reqv/rspv/ready=%b%b%b%b%b required 00000", mem_req_valid_o,
                 ifu_rsp_valid_o, lsu_rsp_valid_o, ifu_req_ready_o, lsu_req_ready_o);
      end
      step();
    end
    mem_rsp_valid_i = 1'b1;
    mem_rdata_i     = rdata;
    #1;
    checks++;
    if ({ifu_rsp_valid_o, lsu_rsp_valid_o} !== {!exp_lsu, exp_lsu}) begin
      failures++;
      $display("FAIL rsp_route: ifu/lsu rsp_valid=%b%b required %b%b", ifu_rsp_valid_o,
               lsu_rsp_valid_o, !exp_lsu, exp_lsu);
    end
    checks++;
    if ((exp_lsu ? lsu_rdata_o : ifu_rdata_o) !== rdata) begin
      failures++;
      $display("FAIL rsp_data: rdata=%h required %h", exp_lsu ? lsu_rdata_o : ifu_rdata_o,
               rdata);
    end
    step();
    mem_rsp_valid_i = 1'b0;
    #1;
    checks++;
    if ({ifu_rsp_valid_o, lsu_rsp_valid_o, mem_req_valid_o} !== 3'b000) begin
      failures++;
      $display("FAIL rsp_one_cycle: ifu/lsu rsp, mem_req_valid=%b%b%b required 000",
               ifu_rsp_valid_o, lsu_rsp_valid_o, mem_req_valid_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    ifu_pend = 1'b0;
    lsu_pend = 1'b0;
    drive_reqs();
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rdata_i     = '0;
    step();
    step();
    checks++;
    if ({ifu_req_ready_o, lsu_req_ready_o, ifu_rsp_valid_o, lsu_rsp_valid_o, mem_req_valid_o,
         mem_addr_o, mem_wen_o, mem_wdata_o, mem_wmask_o, err_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: rdy=%b%b rsp=%b%b mv=%b a=%h w=%b d=%h m=%h err=%b required 0",
               ifu_req_ready_o, lsu_req_ready_o, ifu_rsp_valid_o, lsu_rsp_valid_o,
               mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_wmask_o, err_o);
    end
    rst_i = 1'b0;
    m_last_lsu = 1'b0;
    step();
    checks++;
    if ({ifu_req_ready_o, lsu_req_ready_o, mem_req_valid_o, err_o} !== 4'b0) begin
      failures++;
      $display("FAIL post_reset_idle: rdy=%b%b mv=%b err=%b required 0000", ifu_req_ready_o,
               lsu_req_ready_o, mem_req_valid_o, err_o);
    end
  endtask

  task automatic test_ifu_read();
    bit g;
    ifu_pend = 1'b1;
    ifu_a    = 32'h8000_0000;
    run_one(0, 0, 32'h0000_0413, g);
  endtask

  task automatic test_lsu_write_stall();
    bit g;
    lsu_pend = 1'b1;
    lsu_a    = 32'h8000_1000;
    lsu_w    = 1'b1;
    lsu_d    = 32'hDEAD_BEEF;
    lsu_m    = 4'hF;
    run_one(3, 1, $urandom, g);
  endtask

  task automatic test_busy_ready();
    bit g;
    new_ifu();
    new_lsu();
    run_one(2, 2, $urandom, g);
    run_one(0, 1, $urandom, g);
  endtask

  task automatic test_conflict();
    bit g;
    bit exp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (!ifu_pend) new_ifu();
      if (!lsu_pend) new_lsu();
      exp = Rr ? (i % 2 == 0) : 1'b1;
      run_one(0, 0, $urandom, g);
      checks++;
      if (g !== exp) begin
        failures++;
        $display("FAIL conflict_seq[%0d]: granted_lsu=%b required %b", i, g, exp);
      end
    end
    while (ifu_pend || lsu_pend) run_one(0, 0, $urandom, g);
  endtask

  task automatic test_stray_rsp();
    do_reset();
    mem_rsp_valid_i = 1'b1;
    mem_rdata_i     = 32'h1234_5678;
    #1;
    checks++;
    if ({ifu_rsp_valid_o, lsu_rsp_valid_o} !== 2'b00) begin
      failures++;
      $display("FAIL stray_rsp_route: rsp=%b%b required 00", ifu_rsp_valid_o, lsu_rsp_valid_o);
    end
    step();
    mem_rsp_valid_i = 1'b0;
    repeat (3) begin
      #1;
      checks++;
      if (err_o !== 1'b1) begin
        failures++;
        $display("FAIL stray_err_sticky: err=%b required 1", err_o);
      end
      step();
    end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL err_cleared_by_reset: err=%b required 0", err_o);
    end
    ifu_pend = 1'b1;
    ifu_a    = 32'h8000_0040;
    drive_reqs();
    step();
    ifu_pend = 1'b0;
    drive_reqs();
    mem_req_ready_i = 1'b1;
    step();
    mem_req_ready_i = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    m_last_lsu = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rdata_i     = 32'hCAFE_F00D;
    #1;
    checks++;
    if ({ifu_rsp_valid_o, lsu_rsp_valid_o, mem_req_valid_o} !== 3'b000) begin
      failures++;
      $display("FAIL reset_wait_rsp: rsp=%b%b mv=%b required 000", ifu_rsp_valid_o,
               lsu_rsp_valid_o, mem_req_valid_o);
    end
    step();
    mem_rsp_valid_i = 1'b0;
    lsu_req_valid_i = 1'b1;
    #1;
    checks++;
    if ({err_o, lsu_req_ready_o} !== 2'b11) begin
      failures++;
      $display("FAIL reset_wait_idle: err/lsu_ready=%b%b required 11", err_o, lsu_req_ready_o);
    end
    lsu_req_valid_i = 1'b0;
    step();
  endtask

  task automatic test_random();
    bit g;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if (!ifu_pend && ($urandom_range(0, 1) == 1)) new_ifu();
      if (!lsu_pend && ($urandom_range(0, 1) == 1)) new_lsu();
      if (!ifu_pend && !lsu_pend) new_ifu();
      run_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom, g);
    end
    while (ifu_pend || lsu_pend) run_one(0, 0, $urandom, g);
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL random_no_err: err=%b required 0", err_o);
    end
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_lsu_write_stall();
    test_busy_ready();
    test_conflict();
    test_stray_rsp();
    test_reset_in_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
